serial_adder_n: RTL and testbench

//  - Bit-serial WIDTH-bit adder/subtractor built around one full_adder_one cell; one operand bit per clock.
//  - Generalises the 1-bit combinational full adder to N bits with start/busy/done handshake.
//  - Adds a subtract mode and a signed-overflow flag.
//  - Used in CH3 labs as the area-minimal alternative to a ripple-carry adder.

---
 rtl/serial_adder_n_pkg.sv | 10 +
 rtl/serial_adder_n_full_adder_one.sv | 13 +
 rtl/serial_adder_n.sv | 115 +++++++++++
 tb/tb_serial_adder_n.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/serial_adder_n_pkg.sv
// Shared types for the bit-serial adder/subtractor: FSM state encoding.
package serial_adder_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_n_full_adder_one.sv
// One-bit full adder cell; the only arithmetic element of the serial adder.
module full_adder_one (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic s
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder/subtractor: one operand bit per clock through a
// single full_adder_one, with start/busy/done handshake and signed overflow.
module serial_adder_n
  import serial_adder_n_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_ovf;

  logic             w_sum;
  logic             w_cout;
  logic             w_load;
  logic             w_step;
  logic             w_fin;
  logic [WIDTH:0]   w_cat;
  logic [WIDTH-1:0] w_acc_nxt;

  full_adder_one u_fa (
    .a  (r_opa[0]),
    .b  (r_opb[0]),
    .ci (r_carry),
    .co (w_cout),
    .s  (w_sum)
  );

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
  assign w_cat     = {w_sum, r_acc};
  assign w_acc_nxt = w_cat[WIDTH:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_load) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_fin)  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = w_load ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state == ST_RUN);
    done   = (r_state == ST_DONE);
    w_step = (r_state == ST_RUN);
    w_fin  = (r_state == ST_RUN) && (r_cnt == LAST);
    w_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_opa   <= a;
        r_opb   <= sub ? ~b : b;
        r_carry <= sub ? 1'b1 : ci;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_opa   <= r_opa >> 1;
        r_opb   <= r_opb >> 1;
        r_acc   <= w_acc_nxt;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + CW'(1);
      end
      // On the final step r_carry is the carry into the MSB.
      if (w_fin) begin
        r_s   <= w_acc_nxt;
        r_co  <= w_cout;
        r_ovf <= r_carry ^ w_cout;
      end
    end
  end

  assign s   = r_s;
  assign co  = r_co;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n at WIDTH=8 and WIDTH=1 with hand-computed results.
module tb_serial_adder_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, sub8, ci8;
  logic [7:0] a8, b8, s8;
  logic       busy8, done8, co8, ovf8;
  logic       start1, sub1, ci1;
  logic [0:0] a1, b1, s1;
  logic       busy1, done1, co1, ovf1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .s(s8), .co(co8), .ovf(ovf8)
  );

  serial_adder_n #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .s(s1), .co(co1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the start edge is the following posedge.
  task automatic launch8(input logic sb, input logic [7:0] av, input logic [7:0] bv, input logic c);
    start8 = 1'b1; sub8 = sb; a8 = av; b8 = bv; ci8 = c;
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; ci8 = ~c; sub8 = ~sb;
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait8(input string tag, input logic inject, input logic [7:0] held_s,
                       input logic [7:0] es, input logic eco, input logic eovf);
    int j;
    for (j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 0) chk({tag, "_busy"}, busy8, 1'b1);
      if (j == 2) chk({tag, "_held"}, s8, held_s);
      if (inject && j == 3) start8 = 1'b1;
      if (inject && j == 4) start8 = 1'b0;
      if (done8) break;
    end
    chk({tag, "_lat"}, j, 8);
    chk({tag, "_bz0"}, busy8, 1'b0);
    chk({tag, "_s"}, s8, es);
    chk({tag, "_co"}, co8, eco);
    chk({tag, "_ovf"}, ovf8, eovf);
  endtask

  initial begin
    logic [1:0] sum1;
    logic       seen;
    rst = 1'b1;
    start8 = 0; sub8 = 0; a8 = 0; b8 = 0; ci8 = 0;
    start1 = 0; sub1 = 0; a1 = 0; b1 = 0; ci1 = 0;
    #12;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_s", s8, 0);
    chk("rst_co_ovf", {co8, ovf8}, 0);
    chk("rst_w1", {busy1, done1, s1, co1, ovf1}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    launch8(1'b0, 8'h3C, 8'h45, 1'b0);
    wait8("add3c45", 1'b1, 8'h00, 8'h81, 1'b0, 1'b1);
    @(negedge clk);
    chk("done_pulse1", done8, 1'b0);

    launch8(1'b0, 8'hFF, 8'h01, 1'b1);
    wait8("addff01", 1'b0, 8'h81, 8'h01, 1'b1, 1'b0);
    // back-to-back: start issued during the DONE cycle
    launch8(1'b1, 8'h10, 8'h20, 1'b0);
    wait8("sub1020", 1'b0, 8'h01, 8'hF0, 1'b0, 1'b0);
    launch8(1'b1, 8'h80, 8'h01, 1'b1);
    wait8("sub8001", 1'b0, 8'hF0, 8'h7F, 1'b1, 1'b1);
    launch8(1'b1, 8'h55, 8'h55, 1'b0);
    wait8("sub5555", 1'b0, 8'h7F, 8'h00, 1'b1, 1'b0);
    launch8(1'b0, 8'h7F, 8'h7F, 1'b0);
    wait8("add7f7f", 1'b0, 8'h00, 8'hFE, 1'b0, 1'b1);

    // reset mid-run after three bits
    @(negedge clk);
    launch8(1'b0, 8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_done", done8, 0);
    chk("mid_rst_s", s8, 0);
    chk("mid_rst_co_ovf", {co8, ovf8}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1'b1;
    end
    chk("mid_rst_nodone", seen, 1'b0);

    // WIDTH=1 exhaustive add
    for (int k = 0; k < 8; k++) begin
      start1 = 1'b1; sub1 = 1'b0;
      a1 = k[2:2]; b1 = k[1:1]; ci1 = k[0];
      sum1 = {1'b0, k[2]} + {1'b0, k[1]} + {1'b0, k[0]};
      @(posedge clk);
      #1 start1 = 1'b0;
      @(negedge clk);
      chk($sformatf("w1_busy_%0d", k), {busy1, done1}, 2'b10);
      @(negedge clk);
      chk($sformatf("w1_done_%0d", k), done1, 1'b1);
      chk($sformatf("w1_sum_%0d", k), {co1, s1}, sum1);
      chk($sformatf("w1_ovf_%0d", k), ovf1, k[0] ^ sum1[1]);
    end
    // WIDTH=1 subtract 0-1: s=1, borrow (co=0), ovf=1^0
    start1 = 1'b1; sub1 = 1'b1; a1 = 1'b0; b1 = 1'b1; ci1 = 1'b0;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("w1_sub_done", done1, 1'b1);
    chk("w1_sub", {co1, s1, ovf1}, 3'b011);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1, "timeout");
  end

endmodule
